// File: rtl/axis_frame_checker.sv
// AXI4-Stream sink that checks an incrementing data pattern, tkeep shape and per-frame sideband, and keeps statistics.
// Latency: beat checks at the accepting edge; frame_done/frame_* are visible one cycle after the tlast handshake.
// Backpressure: tready = registered enable AND cfg_ready_mask[phase]; a free-running 3-bit phase sets the pattern.
module axis_frame_checker #(
  parameter int DATA_WIDTH    = 32,
  parameter int USER_WIDTH    = 4,
  parameter int DEST_WIDTH    = 4,
  parameter int ID_WIDTH      = 4,
  parameter int MAX_FRAME_LEN = 256,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic [DEST_WIDTH-1:0]   s_axis_tdest,
  input  logic [ID_WIDTH-1:0]     s_axis_tid,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    cfg_enable,
  input  logic [7:0]              cfg_ready_mask,
  input  logic [DATA_WIDTH-1:0]   cfg_seed,
  output logic                    frame_done,
  output logic [CNT_WIDTH-1:0]    frame_len,
  output logic [DEST_WIDTH-1:0]   frame_dest,
  output logic                    frame_error,
  output logic [CNT_WIDTH-1:0]    frame_count,
  output logic [CNT_WIDTH-1:0]    beat_count,
  output logic [CNT_WIDTH-1:0]    error_count,
  output logic [3:0]              err_sticky
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] MAX_LEN = CNT_WIDTH'(MAX_FRAME_LEN);

  typedef enum logic [1:0] {IDLE, FRAME, DRAIN} state_t;

  typedef struct packed {
    logic [DEST_WIDTH-1:0] dest;
    logic [ID_WIDTH-1:0]   id;
    logic [USER_WIDTH-1:0] user;
  } sideband_t;

  state_t                  state, state_nxt;
  logic                    cfg_enable_q;
  logic [2:0]              phase;
  logic [DATA_WIDTH-1:0]   exp_dat;
  logic [CNT_WIDTH-1:0]    len, len_nxt, len_inc;
  sideband_t               sb_q, sb_in;
  logic                    frm_err, frm_err_nxt;
  logic                    accept, first_beat, complete;
  logic                    data_err, keep_err, sb_err, ovs_err;
  logic [3:0]              beat_errs;
  logic [KEEP_WIDTH-1:0]   keep_p1;
  logic                    keep_contig;

  // tstrb carries no information this checker uses
  logic unused_tstrb;
  assign unused_tstrb = ^s_axis_tstrb;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign s_axis_tready = cfg_enable_q && cfg_ready_mask[phase];
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign sb_in         = '{dest: s_axis_tdest, id: s_axis_tid, user: s_axis_tuser};
  assign len_inc       = sat_inc(len);

  // Per-beat content checks: data pattern, keep shape, sideband consistency
  always_comb begin
    keep_p1     = s_axis_tkeep + KEEP_WIDTH'(1);
    keep_contig = (s_axis_tkeep != '0) && ((s_axis_tkeep & keep_p1) == '0);
    data_err    = accept && (s_axis_tdata != exp_dat);
    keep_err    = accept && (s_axis_tlast ? !keep_contig : !(&s_axis_tkeep));
    sb_err      = accept && (state != IDLE) && (sb_in != sb_q);
    beat_errs   = {ovs_err, sb_err, keep_err, data_err};
    frm_err_nxt = frm_err | (|beat_errs);
  end

  // Frame delimiting: next state, next length, completion and oversize detection
  always_comb begin
    state_nxt  = state;
    len_nxt    = len;
    complete   = 1'b0;
    ovs_err    = 1'b0;
    first_beat = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          first_beat = 1'b1;
          len_nxt    = CNT_ONE;
          if (s_axis_tlast) begin
            complete = 1'b1;
          end else if (CNT_ONE >= MAX_LEN) begin
            ovs_err   = 1'b1;
            state_nxt = DRAIN;
          end else begin
            state_nxt = FRAME;
          end
        end
        FRAME: begin
          len_nxt = len_inc;
          if (s_axis_tlast) begin
            complete  = 1'b1;
            state_nxt = IDLE;
          end else if (len_inc >= MAX_LEN) begin
            ovs_err   = 1'b1;
            state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          len_nxt = len_inc;
          if (s_axis_tlast) begin
            complete  = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath: backpressure phase, expected data, frame tracking and statistics
  always_ff @(posedge aclk) begin
    if (areset) begin
      cfg_enable_q <= 1'b0;
      phase        <= 3'd0;
      exp_dat      <= cfg_seed;
      len          <= '0;
      sb_q         <= '0;
      frm_err      <= 1'b0;
      frame_done   <= 1'b0;
      frame_len    <= '0;
      frame_dest   <= '0;
      frame_error  <= 1'b0;
      frame_count  <= '0;
      beat_count   <= '0;
      error_count  <= '0;
      err_sticky   <= 4'd0;
    end else begin
      cfg_enable_q <= cfg_enable;
      if (cfg_enable_q) phase <= phase + 3'd1;
      frame_done <= complete;
      if (accept) begin
        exp_dat    <= exp_dat + DATA_WIDTH'(1);
        len        <= len_nxt;
        beat_count <= sat_inc(beat_count);
        err_sticky <= err_sticky | beat_errs;
        if (first_beat) sb_q <= sb_in;
        if (complete) begin
          frm_err     <= 1'b0;
          frame_len   <= len_nxt;
          frame_dest  <= first_beat ? s_axis_tdest : sb_q.dest;
          frame_error <= frm_err_nxt;
          frame_count <= sat_inc(frame_count);
          if (frm_err_nxt) error_count <= sat_inc(error_count);
        end else begin
          frm_err <= frm_err_nxt;
        end
      end
    end
  end

endmodule
